// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch stage feeding the IF/ID pipeline register.
//
// Holds the architectural fetch PC and keeps at most one request on the
// instruction bus. If IF/ID is stalled when an instruction returns, the word is
// buffered (HOLD). A redirect that arrives while a fetch is in flight is
// recorded (kill/pending_pc), and the late data is dropped when it arrives.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   ireq_valid, ireq_addr         request to the instruction bus (from registered state)
//   iresp_addr_ok, iresp_data_ok  bus handshake: address accepted / data valid
//   iresp_data                    returned instruction word
//   stallF                        IF/ID not accepting this cycle
//   redirect_valid, redirect_pc   back-end redirect of the fetch stream
//   fetch_valid, dataF            live instruction bundle (combinational)

package fetch_pkg;
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] raw_instr;
    logic        valid;
  } fetch_data_t;
endpackage

module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] PCINIT = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        stallF,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        fetch_valid,
  output fetch_data_t dataF
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state, state_nxt;
  logic [63:0] pc, pc_nxt;
  logic [63:0] pending_pc, pending_nxt;
  logic        kill, kill_nxt;
  logic [31:0] hold_instr, hold_nxt;
  logic        deliver;

  // Instruction data arrives this cycle (the delivery event).
  assign deliver = ((state == S_REQ) && iresp_addr_ok && iresp_data_ok) ||
                   ((state == S_WAIT) && iresp_data_ok);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_REQ;
      pc    <= PCINIT;
      kill  <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      kill  <= kill_nxt;
    end
  end

  // Payload registers are only read under kill / HOLD, so they need no reset.
  always_ff @(posedge clk) begin
    pending_pc <= pending_nxt;
    hold_instr <= hold_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    kill_nxt    = kill;
    pending_nxt = pending_pc;
    hold_nxt    = hold_instr;
    if (deliver) begin
      if (redirect_valid) begin
        pc_nxt    = redirect_pc;
        kill_nxt  = 1'b0;
        state_nxt = S_REQ;
      end else if (kill) begin
        pc_nxt    = pending_pc;
        kill_nxt  = 1'b0;
        state_nxt = S_REQ;
      end else if (!stallF) begin
        pc_nxt    = pc + 64'd4;
        state_nxt = S_REQ;
      end else begin
        hold_nxt  = iresp_data;
        state_nxt = S_HOLD;
      end
    end else if (state == S_HOLD) begin
      if (redirect_valid) begin
        pc_nxt    = redirect_pc;
        state_nxt = S_REQ;
      end else if (!stallF) begin
        pc_nxt    = pc + 64'd4;
        state_nxt = S_REQ;
      end
    end else begin
      // The in-flight request cannot be withdrawn: remember where to go once
      // its data has come back. A later redirect overwrites an earlier one.
      if (redirect_valid) begin
        kill_nxt    = 1'b1;
        pending_nxt = redirect_pc;
      end
      if ((state == S_REQ) && iresp_addr_ok) state_nxt = S_WAIT;
    end
  end

  // Outputs
  always_comb begin
    ireq_valid  = !rst && (state == S_REQ);
    ireq_addr   = pc;
    fetch_valid = !rst && !redirect_valid &&
                  ((deliver && !kill) || (state == S_HOLD));
    dataF       = '0;
    if (!rst) begin
      dataF.pc        = pc;
      dataF.raw_instr = (state == S_HOLD) ? hold_instr : iresp_data;
      dataF.valid     = fetch_valid;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a transaction-level reference model
// predicts every presented instruction into a scoreboard queue; a separate
// monitor pops and compares whenever the DUT raises fetch_valid.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [63:0] PCINIT = 64'h0000_0000_8000_0000;
  localparam int NCYC  = 4000;
  localparam int ISSUE = 0, AWAIT = 1, HELD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok = 1'b0, iresp_data_ok = 1'b0;
  logic [31:0] iresp_data = '0;
  logic        stallF = 1'b0, redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        fetch_valid;
  fetch_data_t dataF;

  fetch_unit #(.PCINIT(PCINIT)) dut (
    .clk(clk), .rst(rst), .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok),
    .iresp_data(iresp_data), .stallF(stallF), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .fetch_valid(fetch_valid), .dataF(dataF)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [63:0] pc; logic [31:0] instr; } exp_t;
  exp_t sb[$];

  int checks = 0, errors = 0, cyc = 0;
  bit done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Reference model: the fetch PC, where the current fetch stands (ISSUE /
  // AWAIT / HELD), the buffered word, and an optional "drop and go to" target.
  logic [63:0] m_pc = PCINIT;
  int          m_phase = ISSUE;
  logic [31:0] m_buf = '0;
  logic [63:0] m_drop[$];

  initial begin : driver
    bit zw, arrived, held, e_iv, e_fv;
    int rst_left;
    rst_left = 3;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk); #1;
      cyc++;
      // Stimulus: a zero-wait unstalled stream first, then random traffic.
      zw  = (cyc < 40);
      if (rst_left == 0 && !zw && $urandom_range(0, 499) == 0) rst_left = $urandom_range(1, 2);
      rst = (rst_left > 0);
      if (rst_left > 0) rst_left--;
      iresp_data     = $urandom;
      iresp_addr_ok  = (m_phase == ISSUE) && (zw || $urandom_range(0, 9) < 6);
      iresp_data_ok  = ((m_phase == ISSUE) && iresp_addr_ok && (zw || $urandom_range(0, 1) == 1)) ||
                       ((m_phase == AWAIT) && (zw || $urandom_range(0, 1) == 1));
      stallF         = !zw && ($urandom_range(0, 9) < 3);
      redirect_valid = !zw && ($urandom_range(0, 99) < 8);
      redirect_pc    = ($urandom_range(0, 9) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC
                                                   : ({$urandom, $urandom} & ~64'd3);

      // Prediction for this cycle.
      arrived = ((m_phase == ISSUE) && iresp_addr_ok && iresp_data_ok) ||
                ((m_phase == AWAIT) && iresp_data_ok);
      held    = (m_phase == HELD);
      e_iv    = !rst && (m_phase == ISSUE);
      e_fv    = !rst && !redirect_valid && ((arrived && m_drop.size() == 0) || held);
      if (e_fv) sb.push_back('{cyc, m_pc, held ? m_buf : iresp_data});

      #1;
      check("ireq_valid", {63'd0, ireq_valid}, {63'd0, e_iv});
      if (e_iv) check("ireq_addr", ireq_addr, m_pc);
      if (rst) begin
        check("rst_fetch_valid", {63'd0, fetch_valid}, 64'd0);
        check("rst_dataF_zero", {63'd0, dataF != '0}, 64'd0);
      end

      // Advance the model.
      if (rst) begin
        m_pc = PCINIT; m_phase = ISSUE; m_drop.delete();
      end else if (arrived || held) begin
        if (redirect_valid) begin
          m_pc = redirect_pc; m_phase = ISSUE; m_drop.delete();
        end else if (arrived && m_drop.size() != 0) begin
          m_pc = m_drop.pop_front(); m_phase = ISSUE;
        end else if (!stallF) begin
          m_pc = m_pc + 64'd4; m_phase = ISSUE;
        end else if (arrived) begin
          m_buf = iresp_data; m_phase = HELD;
        end
      end else begin
        if (redirect_valid) begin
          m_drop.delete(); m_drop.push_back(redirect_pc);
        end
        if (m_phase == ISSUE && iresp_addr_ok) m_phase = AWAIT;
      end
    end
    @(negedge clk); #1;
    done = 1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) break;
      check("valid_mirror", {63'd0, dataF.valid}, {63'd0, fetch_valid});
      if (fetch_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_fetch", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("fetch_cycle", 64'(e.cyc), 64'(cyc));
          check("fetch_pc", dataF.pc, e.pc);
          check("fetch_instr", {32'd0, dataF.raw_instr}, {32'd0, e.instr});
        end
      end else if (sb.size() != 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        check("missing_fetch", 64'd0, 64'd1);
      end
    end
  end

endmodule
